// File: rtl/axis_demod_seq.sv
// Frame sequencer between a 16-QAM demodulator and an AXI-Stream sink.
// Define DEMOD_SEQ_WDOG_EN to compile in the stall watchdog that drives err.
module axis_demod_seq #(
  parameter int SYM_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             start,
  input  logic             abort,
  input  logic [SYM_W-1:0] n_sym,
  output logic             demod_en,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SYM_W-1:0] sym_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [SYM_W-1:0] SYM_ONE = 1;
  localparam logic [SYM_W-1:0] SYM_MAX = '1;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("axis_demod_seq: TIMEOUT must be in 2..65535");
  end

  logic [1:0]       state_reg, state_next;
  logic [SYM_W-1:0] sym_cnt_reg;
  logic [SYM_W-1:0] n_sym_reg;
  logic             in_run, in_flush;
  logic             s_hs;
  logic             sym_end, final_end;
  logic             accept;
  logic             timeout;

  assign in_run    = (state_reg == RUN);
  assign in_flush  = (state_reg == FLUSH);
  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign sym_end   = in_run && s_axis_tvalid && m_axis_tready && s_axis_tlast;
  assign final_end = sym_end && (sym_cnt_reg == n_sym_reg - SYM_ONE);
  assign accept    = (state_reg == IDLE) && start && !abort && (n_sym != '0);

`ifdef DEMOD_SEQ_WDOG_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);
  logic [15:0] wdog_reg;

  // Fires only on a cycle with no handshake, so no beat is lost to a timeout.
  assign timeout = (in_run || in_flush) && !s_hs && (wdog_reg == WDOG_LIMIT);

  always_ff @(posedge aclk) begin
    if (areset) begin
      wdog_reg <= '0;
    end else if (!(in_run || in_flush) || s_hs || (state_next != state_reg)) begin
      wdog_reg <= '0;
    end else begin
      wdog_reg <= wdog_reg + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        // The last symbol end beats a coincident abort.
        if (final_end)    state_next = DONE;
        else if (abort)   state_next = FLUSH;
        else if (timeout) state_next = IDLE;
      end
      FLUSH: begin
        if (s_axis_tvalid && s_axis_tlast) state_next = IDLE;
        else if (timeout)                  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg   <= IDLE;
      sym_cnt_reg <= '0;
      n_sym_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        n_sym_reg   <= n_sym;
        sym_cnt_reg <= '0;
      end else if (sym_end && (sym_cnt_reg != SYM_MAX)) begin
        sym_cnt_reg <= sym_cnt_reg + SYM_ONE;
      end
    end
  end

  assign demod_en      = in_run || in_flush;
  assign s_axis_tready = in_run ? m_axis_tready : in_flush;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = in_run && s_axis_tvalid;
  assign m_axis_tlast  = final_end;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign err           = timeout;
  assign sym_cnt       = sym_cnt_reg;

endmodule

// File: tb/tb_axis_demod_seq.sv
// Scoreboard bench for axis_demod_seq: random frames, aborts, resets and the
// watchdog (exercised when DEMOD_SEQ_WDOG_EN is defined).
module tb_axis_demod_seq;
  localparam int SYM_W   = 8;
  localparam int TIMEOUT = 16;

  logic             aclk = 1'b0;
  logic             areset;
  logic             start, abort;
  logic [SYM_W-1:0] n_sym;
  logic             demod_en;
  logic [31:0]      s_axis_tdata;
  logic             s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic             busy, done, err;
  logic [SYM_W-1:0] sym_cnt;

  always #5 aclk = ~aclk;

  axis_demod_seq #(.SYM_W(SYM_W), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort), .n_sym(n_sym),
    .demod_en(demod_en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .err(err), .sym_cnt(sym_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];
  beat_t frame_q[$];
  beat_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted output beat is popped from the scoreboard.
  always @(negedge aclk) begin
    if (areset === 1'b0 && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat actual=%08h required=none", m_axis_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("m_tdata", m_axis_tdata, mon_e.data);
        chk("m_tlast", {31'd0, m_axis_tlast}, {31'd0, mon_e.last});
        $display("beat data=%08h last=%0d", m_axis_tdata, m_axis_tlast);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  // Frame as a flat list of beats; bps==0 picks 1..4 beats per symbol.
  task automatic build_frame(input int n, input int bps);
    frame_q.delete();
    for (int s = 0; s < n; s++) begin
      int nb;
      nb = (bps == 0) ? $urandom_range(1, 4) : bps;
      for (int b = 0; b < nb; b++) begin
        beat_t x;
        x.data = $urandom;
        x.last = (b == nb - 1);
        frame_q.push_back(x);
      end
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    n_sym = SYM_W'(n);
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  // rmode: 0 ready always, 1 ready toggles every cycle, 2 random.
  task automatic drive_beat(input beat_t b, input int rmode, input bit do_abort,
                            input bit flushing, output bit ok);
    int idle;
    bit hs;
    bit force_go;
    idle = 0;
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      force_go = do_abort || (idle >= 4);
      s_axis_tvalid = force_go || flushing || ($urandom_range(0, 3) != 0);
      s_axis_tdata  = b.data;
      s_axis_tlast  = b.last;
      case (rmode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = do_abort ? 1'b1 : ~m_axis_tready;
        default: m_axis_tready = force_go || ($urandom_range(0, 3) != 0);
      endcase
      abort = do_abort;
      @(negedge aclk);
      if (flushing) begin
        chk("flush_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("flush_s_tready", {31'd0, s_axis_tready}, 32'd1);
      end else begin
        chk("s_tready_mirror", {31'd0, s_axis_tready}, {31'd0, m_axis_tready});
      end
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge aclk); #1;
      abort = 1'b0;
      if (hs) begin
        ok = 1'b1;
        s_axis_tvalid = 1'b0;
        return;
      end
      idle++;
    end
    s_axis_tvalid = 1'b0;
    total++;
    bad++;
    $display("FAIL beat_handshake actual=no_handshake required=handshake");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},     {31'd0, busy},          32'd0);
    chk({tag, "_done"},     {31'd0, done},          32'd0);
    chk({tag, "_err"},      {31'd0, err},           32'd0);
    chk({tag, "_demod_en"}, {31'd0, demod_en},      32'd0);
    chk({tag, "_s_tready"}, {31'd0, s_axis_tready}, 32'd0);
    chk({tag, "_m_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
    chk({tag, "_m_tlast"},  {31'd0, m_axis_tlast},  32'd0);
    chk({tag, "_sym_cnt"},  32'(sym_cnt),           32'd0);
  endtask

  // abort_at < 0: full frame; otherwise abort on that beat index.
  task automatic run_frame(input int n, input int bps, input int rmode,
                           input int abort_at, input bit start_busy);
    int upto;
    int exp_sym;
    bit ok;
    build_frame(n, bps);
    upto = (abort_at < 0) ? frame_q.size() - 1 : abort_at;
    exp_sym = 0;
    for (int i = 0; i <= upto; i++) begin
      beat_t e;
      e.data = frame_q[i].data;
      e.last = (i == frame_q.size() - 1);
      exp_q.push_back(e);
      if (frame_q[i].last) exp_sym++;
    end
    do_start(n);
    if (start_busy) begin
      start = 1'b1;
      n_sym = SYM_W'(1);
    end
    @(negedge aclk);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_demod_en", {31'd0, demod_en}, 32'd1);
    @(posedge aclk); #1;
    start = 1'b0;
    for (int i = 0; i <= upto; i++) begin
      drive_beat(frame_q[i], rmode, (i == abort_at), 1'b0, ok);
      if (!ok) return;
    end
    if (upto != frame_q.size() - 1) begin
      for (int i = upto + 1; i < frame_q.size(); i++) begin
        drive_beat(frame_q[i], rmode, 1'b0, 1'b1, ok);
        if (!ok || frame_q[i].last) break;
      end
      @(negedge aclk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_sym_cnt", 32'(sym_cnt), 32'(exp_sym));
    end else begin
      @(negedge aclk);
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_sym_cnt", 32'(sym_cnt), 32'(exp_sym));
      chk("done_demod_en", {31'd0, demod_en}, 32'd0);
      chk("done_s_tready", {31'd0, s_axis_tready}, 32'd0);
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("after_done", {31'd0, done}, 32'd0);
      chk("after_busy", {31'd0, busy}, 32'd0);
      chk("after_sym_cnt", 32'(sym_cnt), 32'(exp_sym));
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("frame n_sym=%0d beats=%0d abort_at=%0d sym_cnt=%0d", n, frame_q.size(), abort_at, sym_cnt);
  endtask

  initial begin
    bit ok;
    int cnt;
    areset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    n_sym = '0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check_reset_outputs("reset");

    run_frame(3, 4, 0, -1, 1'b0);
    run_frame(3, 4, 1, -1, 1'b0);
    run_frame(3, 4, 0, 5, 1'b0);

    do_start(0);
    @(negedge aclk);
    chk("start_nsym0_ignored", {31'd0, busy}, 32'd0);
    abort = 1'b1;
    do_start(3);
    abort = 1'b0;
    @(negedge aclk);
    chk("start_with_abort_ignored", {31'd0, busy}, 32'd0);
    run_frame(3, 4, 0, 11, 1'b1);

    // Stall in RUN after three beats.
    build_frame(2, 4);
    for (int i = 0; i < 3; i++) exp_q.push_back('{frame_q[i].data, 1'b0});
    do_start(2);
    for (int i = 0; i < 3; i++) drive_beat(frame_q[i], 0, 1'b0, 1'b0, ok);
    m_axis_tready = 1'b1;
    cnt = 0;
`ifdef DEMOD_SEQ_WDOG_EN
    for (int t = 0; t < 40; t++) begin
      @(negedge aclk);
      cnt++;
      if (err) break;
      @(posedge aclk); #1;
    end
    chk("wdog_err_cycle", 32'(cnt), 32'(TIMEOUT));
    chk("wdog_no_tlast", {31'd0, m_axis_tlast}, 32'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("wdog_idle", {31'd0, busy}, 32'd0);
    chk("wdog_err_pulse", {31'd0, err}, 32'd0);
    chk("wdog_no_done", {31'd0, done}, 32'd0);
`else
    for (int t = 0; t < 40; t++) begin
      @(negedge aclk);
      if (err) cnt++;
      @(posedge aclk); #1;
    end
    chk("nowdog_err_count", 32'(cnt), 32'd0);
    chk("nowdog_still_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(posedge aclk); #1;
    abort = 1'b0;
    drive_beat(frame_q[3], 0, 1'b0, 1'b1, ok);
    @(negedge aclk);
    chk("nowdog_flush_idle", {31'd0, busy}, 32'd0);
`endif
    chk("stall_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("stall test err_cycles=%0d", cnt);

    // Reset in the middle of a frame, while beat 6 is presented.
    build_frame(3, 4);
    for (int i = 0; i < 5; i++) exp_q.push_back('{frame_q[i].data, 1'b0});
    do_start(3);
    for (int i = 0; i < 5; i++) drive_beat(frame_q[i], 0, 1'b0, 1'b0, ok);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = frame_q[5].data;
    s_axis_tlast = frame_q[5].last;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    check_reset_outputs("midreset");
    chk("midreset_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("mid-frame reset applied");

    for (int f = 0; f < 10; f++) begin
      int n;
      int ab;
      n = $urandom_range(1, 4);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n * 2 - 1) : -1;
      run_frame(n, 2, 2, ab, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
